// File: rtl/pipelined_shifter.sv
// pipelined_shifter: N-bit log shifter split into LOG2N pipeline stages, one
// barrel level (shift by 2^s) per stage register. Supports SLL, SRL and SRA.
// The handshake is valid/ready on both sides. The whole pipe advances as one
// unit, so bubbles are not compressed.
//
// Optional feature macro: ROTATE_EN
//   defined   -> op 2'b11 rotates right by B mod N (no saturation)
//   undefined -> op 2'b11 behaves exactly like SRL; no rotate logic exists
module pipelined_shifter #(
    parameter int N  = 32,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic [1:0]    op,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  Z,
    output logic [TW-1:0] out_tag
);

    localparam int LOG2N = $clog2(N);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One barrel level: shift d by k in the direction given by o.
    // SRL and SRA share a path because fill is already 0 for SRL.
    function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d,
                                                 input int          k,
                                                 input logic [1:0]  o,
                                                 input logic        f);
        logic [N-1:0] r;
        logic [N-1:0] fill_mask;
        fill_mask = ~({N{1'b1}} >> k);
        case (o)
            OP_SLL:  r = d << k;
`ifdef ROTATE_EN
            OP_ROR:  r = (d >> k) | (d << (N - k));
`endif
            default: r = (d >> k) | (f ? fill_mask : {N{1'b0}});
        endcase
        return r;
    endfunction

    // Entry-side signals feeding stage 0
    logic             sat_s;
    logic [1:0]       op_e_s;
    logic             fill_e_s;
    logic [N-1:0]     data_e_s;
    logic [LOG2N-1:0] shamt_e_s;
    logic             adv_s;

    // Stage inputs (entry for stage 0, previous register otherwise)
    logic [N-1:0]     sin_data_s  [LOG2N];
    logic [LOG2N-1:0] sin_shamt_s [LOG2N];
    logic [1:0]       sin_op_s    [LOG2N];
    logic             sin_fill_s  [LOG2N];
    logic [TW-1:0]    sin_tag_s   [LOG2N];
    logic             sin_valid_s [LOG2N];

    // Stage registers and their next-state values
    logic [N-1:0]     data_q  [LOG2N];
    logic [N-1:0]     data_d  [LOG2N];
    logic [LOG2N-1:0] shamt_q [LOG2N];
    logic [LOG2N-1:0] shamt_d [LOG2N];
    logic [1:0]       op_q    [LOG2N];
    logic [1:0]       op_d    [LOG2N];
    logic             fill_q  [LOG2N];
    logic             fill_d  [LOG2N];
    logic [TW-1:0]    tag_q   [LOG2N];
    logic [TW-1:0]    tag_d   [LOG2N];
    logic             valid_q [LOG2N];
    logic             valid_d [LOG2N];

    // The whole pipe moves unless the final result is waiting on the consumer
    assign adv_s     = !valid_q[LOG2N-1] || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = valid_q[LOG2N-1];
    assign Z         = data_q[LOG2N-1];
    assign out_tag   = tag_q[LOG2N-1];

    // Entry decode: resolve the effective op, saturation, fill bit and shift amount
    always_comb begin
        op_e_s    = op;
        sat_s     = |B[N-1:LOG2N];
        data_e_s  = A;
        shamt_e_s = B[LOG2N-1:0];
`ifndef ROTATE_EN
        if (op == OP_ROR) begin
            op_e_s = OP_SRL;
        end else begin
            op_e_s = op;
        end
`endif
        fill_e_s = (op_e_s == OP_SRA) ? A[N-1] : 1'b0;
        case (op_e_s)
            OP_SLL, OP_SRL: begin
                if (sat_s) begin
                    data_e_s  = {N{1'b0}};
                    shamt_e_s = {LOG2N{1'b0}};
                end else begin
                    data_e_s  = A;
                    shamt_e_s = B[LOG2N-1:0];
                end
            end
            OP_SRA: begin
                if (sat_s) begin
                    data_e_s  = {N{A[N-1]}};
                    shamt_e_s = {LOG2N{1'b0}};
                end else begin
                    data_e_s  = A;
                    shamt_e_s = B[LOG2N-1:0];
                end
            end
            default: begin
                // rotate: amount is B mod N, upper bits of B do not saturate
                data_e_s  = A;
                shamt_e_s = B[LOG2N-1:0];
            end
        endcase
    end

    // Route each stage's input: entry values for stage 0, prior register after
    always_comb begin
        sin_data_s[0]  = data_e_s;
        sin_shamt_s[0] = shamt_e_s;
        sin_op_s[0]    = op_e_s;
        sin_fill_s[0]  = fill_e_s;
        sin_tag_s[0]   = in_tag;
        sin_valid_s[0] = in_valid;
        for (int s = 1; s < LOG2N; s++) begin
            sin_data_s[s]  = data_q[s-1];
            sin_shamt_s[s] = shamt_q[s-1];
            sin_op_s[s]    = op_q[s-1];
            sin_fill_s[s]  = fill_q[s-1];
            sin_tag_s[s]   = tag_q[s-1];
            sin_valid_s[s] = valid_q[s-1];
        end
    end

    // Per-stage barrel level; bubbles load zeros so Z and out_tag read 0 when idle
    always_comb begin
        for (int s = 0; s < LOG2N; s++) begin
            valid_d[s] = sin_valid_s[s];
            if (sin_valid_s[s]) begin
                if (sin_shamt_s[s][s]) begin
                    data_d[s] = stage_shift(sin_data_s[s], int'(32'd1 << s),
                                            sin_op_s[s], sin_fill_s[s]);
                end else begin
                    data_d[s] = sin_data_s[s];
                end
                shamt_d[s] = sin_shamt_s[s];
                op_d[s]    = sin_op_s[s];
                fill_d[s]  = sin_fill_s[s];
                tag_d[s]   = sin_tag_s[s];
            end else begin
                data_d[s]  = {N{1'b0}};
                shamt_d[s] = {LOG2N{1'b0}};
                op_d[s]    = 2'b00;
                fill_d[s]  = 1'b0;
                tag_d[s]   = {TW{1'b0}};
            end
        end
    end

    // Stage registers: cleared on reset, advance together, hold during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LOG2N; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= {N{1'b0}};
                shamt_q[s] <= {LOG2N{1'b0}};
                op_q[s]    <= 2'b00;
                fill_q[s]  <= 1'b0;
                tag_q[s]   <= {TW{1'b0}};
            end
        end else if (adv_s) begin
            for (int s = 0; s < LOG2N; s++) begin
                valid_q[s] <= valid_d[s];
                data_q[s]  <= data_d[s];
                shamt_q[s] <= shamt_d[s];
                op_q[s]    <= op_d[s];
                fill_q[s]  <= fill_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

endmodule
